// File: rtl/axi_dma_pkg.sv
// Shared constants and FSM encoding for the AXI DMA write staging buffer.
// One beat spans BEAT_ADDR_UNITS address units; a burst spans 2**ssub_width() units.
package axi_dma_pkg;

    localparam int BEAT_ADDR_UNITS = 8;
    localparam int BEAT_SHIFT      = $clog2(BEAT_ADDR_UNITS);

    typedef enum logic [1:0] {
        RECV = 2'd0,
        PAD  = 2'd1,
        DESC = 2'd2
    } wr_state_t;

    // Address bits covered by one whole burst (beat units plus beats per burst).
    function automatic int ssub_width(input int burst_len);
        return BEAT_SHIFT + $clog2(burst_len);
    endfunction

    localparam int SSUB_WIDTH = ssub_width(8);

endpackage

// File: rtl/axi_dma_wr_buf_if.sv
// Handshake bundle between the staging buffer and its neighbours:
// the input beat stream, the descriptor channel and the write-interface read port.
interface axi_dma_wr_buf_if #(
    parameter int AXI_DATA_WIDTH = 128,
    parameter int ADDR_WIDTH     = 25,
    parameter int LEN_WIDTH      = 20
);
    logic [AXI_DATA_WIDTH-1:0] s_data;
    logic                      s_valid;
    logic                      s_last;
    logic                      s_ready;

    logic [ADDR_WIDTH-1:0]     cfg_desc_addr;
    logic [LEN_WIDTH-1:0]      cfg_desc_len;
    logic                      cfg_valid;
    logic                      cfg_ready;

    logic                      if_rd_pop;
    logic [AXI_DATA_WIDTH-1:0] if_rd_data;
    logic                      if_rd_ready;
    logic                      if_rd_req;
    logic                      st_last;

    modport slave (
        input  s_data, s_valid, s_last, cfg_ready, if_rd_pop, st_last,
        output s_ready, cfg_desc_addr, cfg_desc_len, cfg_valid,
               if_rd_data, if_rd_ready, if_rd_req
    );

    modport master (
        output s_data, s_valid, s_last, cfg_ready, if_rd_pop, st_last,
        input  s_ready, cfg_desc_addr, cfg_desc_len, cfg_valid,
               if_rd_data, if_rd_ready, if_rd_req
    );

endinterface

// File: rtl/axi_dma_wr_buf_fifo.sv
// First-word-fall-through FIFO: the head word is visible on rd_data whenever not empty.
// Writes when full and reads when empty are ignored; count updates at the clock edge.
module axi_dma_fwft_fifo #(
    parameter int WIDTH = 128,
    parameter int DEPTH = 512
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             wr_ok;
    logic             rd_ok;

    assign empty = (count == '0);
    assign full  = (count == (PTR_W+1)'(DEPTH));
    assign wr_ok = wr_en && !full;
    assign rd_ok = rd_en && !empty;

    // Empty FIFO presents zero so the head bus is clean during and after reset.
    assign rd_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/axi_dma_wr_buf.sv
// Staging buffer in front of the AXI DMA write interface: buffers packets, zero-pads
// each to whole bursts and issues one address/length descriptor per packet.
module axi_dma_wr_buf
    import axi_dma_pkg::*;
#(
    parameter int AXI_DATA_WIDTH = 128,
    parameter int BURST_LEN      = 8,
    parameter int LEN_WIDTH      = 20,
    parameter int BANK_WIDTH     = 3,
    parameter int SEC_WIDTH      = 2,
    parameter int SUB_WIDTH      = LEN_WIDTH,
    parameter int ADDR_WIDTH     = BANK_WIDTH + SEC_WIDTH + SUB_WIDTH,
    parameter int FIFO_DEPTH     = 512
) (
    input  logic                   aclk,
    input  logic                   areset,
    axi_dma_wr_buf_if.slave        bus,
    input  logic [ADDR_WIDTH-1:0]  cfg_base_addr,
    input  logic                   cfg_reload,
    output logic [7:0]             pkt_pending,
    output logic                   ovf
);

    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
    localparam int BL_W   = $clog2(BURST_LEN);
    localparam int SSUB_W = ssub_width(BURST_LEN);
    localparam int HI_W   = BANK_WIDTH + SEC_WIDTH;

    wr_state_t                 state;
    logic                      init_done;
    logic [CNT_W-1:0]          pkt_beats;
    logic [CNT_W-1:0]          beats_next;
    logic [SUB_WIDTH-1:0]      sub_ptr;
    logic [HI_W-1:0]           base_hi;
    logic [ADDR_WIDTH-1:0]     desc_addr;
    logic [LEN_WIDTH-1:0]      desc_len;

    logic                      fifo_full;
    logic                      fifo_empty;
    logic [CNT_W-1:0]          fifo_count;
    logic                      fifo_wr;
    logic [AXI_DATA_WIDTH-1:0] fifo_wr_data;

    logic                      dropping;
    logic                      s_fire;
    logic                      beat_store;
    logic                      pad_wr;
    logic                      desc_fire;
    logic                      burst_aligned;
    logic                      reload_ok;

    // Once a packet has filled the whole FIFO its tail is accepted but discarded,
    // so the descriptor length can never exceed what is actually buffered.
    assign dropping      = (pkt_beats == CNT_W'(FIFO_DEPTH));
    assign bus.s_ready   = init_done && (state == RECV) && (dropping || !fifo_full);
    assign s_fire        = bus.s_valid && bus.s_ready;
    assign beat_store    = s_fire && !dropping;
    assign pad_wr        = (state == PAD) && !fifo_full;
    assign fifo_wr       = beat_store || pad_wr;
    assign fifo_wr_data  = (state == PAD) ? '0 : bus.s_data;
    assign beats_next    = pkt_beats + CNT_W'(fifo_wr);
    assign burst_aligned = ((beats_next & CNT_W'(BURST_LEN - 1)) == '0);
    assign desc_fire     = (state == DESC) && bus.cfg_ready;
    assign reload_ok     = cfg_reload && (state == RECV) && (pkt_beats == '0);

    assign bus.cfg_valid     = (state == DESC);
    assign bus.cfg_desc_addr = desc_addr;
    assign bus.cfg_desc_len  = desc_len;
    assign bus.if_rd_ready   = !fifo_empty;
    assign bus.if_rd_req     = (fifo_count >= CNT_W'(BURST_LEN));

    axi_dma_fwft_fifo #(
        .WIDTH (AXI_DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (aclk),
        .rst     (areset),
        .wr_en   (fifo_wr),
        .wr_data (fifo_wr_data),
        .rd_en   (bus.if_rd_pop),
        .rd_data (bus.if_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    // Packet FSM; the first cycle after reset release only loads the base address.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state     <= RECV;
            init_done <= 1'b0;
            pkt_beats <= '0;
            sub_ptr   <= '0;
            base_hi   <= '0;
            desc_addr <= '0;
            desc_len  <= '0;
            ovf       <= 1'b0;
        end else if (!init_done) begin
            init_done <= 1'b1;
            sub_ptr   <= cfg_base_addr[SUB_WIDTH-1:0];
            base_hi   <= HI_W'(cfg_base_addr[ADDR_WIDTH-1:SUB_WIDTH]);
        end else begin
            case (state)
                RECV: begin
                    if (reload_ok) begin
                        sub_ptr <= cfg_base_addr[SUB_WIDTH-1:0];
                        base_hi <= HI_W'(cfg_base_addr[ADDR_WIDTH-1:SUB_WIDTH]);
                    end
                    if (s_fire) begin
                        pkt_beats <= beats_next;
                        if (dropping) begin
                            ovf <= 1'b1;
                        end
                        if (bus.s_last) begin
                            if (burst_aligned) begin
                                state     <= DESC;
                                desc_addr <= ADDR_WIDTH'({base_hi, sub_ptr});
                                desc_len  <= LEN_WIDTH'(beats_next >> BL_W) << SSUB_W;
                            end else begin
                                state <= PAD;
                            end
                        end
                    end
                end
                PAD: begin
                    if (pad_wr) begin
                        pkt_beats <= beats_next;
                        if (burst_aligned) begin
                            state     <= DESC;
                            desc_addr <= ADDR_WIDTH'({base_hi, sub_ptr});
                            desc_len  <= LEN_WIDTH'(beats_next >> BL_W) << SSUB_W;
                        end
                    end
                end
                DESC: begin
                    if (bus.cfg_ready) begin
                        sub_ptr   <= sub_ptr + SUB_WIDTH'(desc_len);
                        pkt_beats <= '0;
                        state     <= RECV;
                    end
                end
                default: begin
                    state <= RECV;
                end
            endcase
        end
    end

    // Outstanding descriptors; a completion and an issue in one cycle cancel out.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            pkt_pending <= '0;
        end else begin
            case ({desc_fire, bus.st_last})
                2'b10: begin
                    if (pkt_pending != 8'hFF) begin
                        pkt_pending <= pkt_pending + 8'd1;
                    end
                end
                2'b01: begin
                    if (pkt_pending != 8'h00) begin
                        pkt_pending <= pkt_pending - 8'd1;
                    end
                end
                default: pkt_pending <= pkt_pending;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_dma_wr_buf.sv
// Scoreboard bench for axi_dma_wr_buf: stimulus queues expected beats and descriptors,
// a negedge monitor compares them as the DUT hands them over.
module tb_axi_dma_wr_buf;

    localparam int DW    = 128;
    localparam int BL    = 8;
    localparam int LW    = 20;
    localparam int AW    = 25;
    localparam int DEPTH = 16;

    logic          aclk = 1'b0;
    logic          areset;
    logic [AW-1:0] cfg_base_addr;
    logic          cfg_reload;
    logic [7:0]    pkt_pending;
    logic          ovf;

    axi_dma_wr_buf_if #(.AXI_DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) bus ();

    axi_dma_wr_buf #(
        .AXI_DATA_WIDTH (DW),
        .BURST_LEN      (BL),
        .LEN_WIDTH      (LW),
        .BANK_WIDTH     (3),
        .SEC_WIDTH      (2),
        .FIFO_DEPTH     (DEPTH)
    ) dut (
        .aclk          (aclk),
        .areset        (areset),
        .bus           (bus),
        .cfg_base_addr (cfg_base_addr),
        .cfg_reload    (cfg_reload),
        .pkt_pending   (pkt_pending),
        .ovf           (ovf)
    );

    always #5 aclk = ~aclk;

    int                  vectors     = 0;
    int                  miscompares = 0;
    logic [AW+LW-1:0]    exp_desc[$];
    logic [DW-1:0]       exp_data[$];
    logic [LW-1:0]       exp_sub;

    task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic reportFail(input string name);
        vectors++;
        miscompares++;
        $display("[TB] FAIL %s: got timeout/unexpected event, expected none", name);
    endtask

    function automatic logic [DW-1:0] mkBeat(input int pkt, input int idx);
        return {1'b1, 111'd0, pkt[7:0], idx[7:0]};
    endfunction

    // Monitor: descriptor and read-port handovers are checked against the queues.
    initial begin
        forever begin
            @(negedge aclk);
            if (!areset && bus.cfg_valid && bus.cfg_ready) begin
                if (exp_desc.size() == 0) reportFail("unexpected_desc");
                else checkOutput("desc", DW'({bus.cfg_desc_addr, bus.cfg_desc_len}), DW'(exp_desc.pop_front()));
            end
            if (!areset && bus.if_rd_pop && bus.if_rd_ready) begin
                if (exp_data.size() == 0) reportFail("unexpected_pop");
                else checkOutput("rd_data", bus.if_rd_data, exp_data.pop_front());
            end
        end
    end

    task automatic sendBeat(input logic [DW-1:0] d, input logic last);
        int n = 0;
        bus.s_data  = d;
        bus.s_valid = 1'b1;
        bus.s_last  = last;
        while (1) begin
            @(negedge aclk);
            if (bus.s_ready) break;
            n++;
            if (n > 200) begin
                reportFail("s_ready_timeout");
                break;
            end
        end
        @(posedge aclk);
        #1;
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
    endtask

    task automatic pushDesc(input int padded);
        exp_desc.push_back({cfg_base_addr[AW-1:LW], exp_sub, LW'(padded * 8)});
        exp_sub = exp_sub + LW'(padded * 8);
    endtask

    // Sends a whole packet; beats beyond the FIFO depth are expected to be dropped.
    task automatic applyStimulus(input int pkt, input int nbeats);
        int stored = (nbeats > DEPTH) ? DEPTH : nbeats;
        int padded = ((stored + BL - 1) / BL) * BL;
        for (int i = 0; i < stored; i++) exp_data.push_back(mkBeat(pkt, i));
        for (int i = stored; i < padded; i++) exp_data.push_back('0);
        pushDesc(padded);
        for (int i = 0; i < nbeats; i++) sendBeat(mkBeat(pkt, i), i == nbeats - 1);
    endtask

    task automatic waitDescriptor(input int budget);
        int n = 0;
        while (exp_desc.size() != 0 && n < budget) begin
            @(posedge aclk);
            n++;
        end
        if (exp_desc.size() != 0) reportFail("desc_timeout");
        @(posedge aclk);
        #1;
    endtask

    task automatic popBeats(input int n);
        for (int i = 0; i < n; i++) begin
            bus.if_rd_pop = 1'b1;
            @(posedge aclk);
            #1;
            bus.if_rd_pop = 1'b0;
        end
    endtask

    task automatic pulseStLast();
        bus.st_last = 1'b1;
        @(posedge aclk);
        #1;
        bus.st_last = 1'b0;
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_s_ready"}, DW'(bus.s_ready), '0);
        checkOutput({tag, "_cfg_valid"}, DW'(bus.cfg_valid), '0);
        checkOutput({tag, "_rd_ready"}, DW'(bus.if_rd_ready), '0);
        checkOutput({tag, "_rd_req"}, DW'(bus.if_rd_req), '0);
        checkOutput({tag, "_rd_data"}, bus.if_rd_data, '0);
        checkOutput({tag, "_pending"}, DW'(pkt_pending), '0);
        checkOutput({tag, "_ovf"}, DW'(ovf), '0);
        checkOutput({tag, "_desc_addr"}, DW'(bus.cfg_desc_addr), '0);
        checkOutput({tag, "_desc_len"}, DW'(bus.cfg_desc_len), '0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no end of test, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        areset        = 1'b0;
        cfg_reload    = 1'b0;
        cfg_base_addr = {3'd5, 2'd2, 20'd0};
        exp_sub       = '0;
        bus.s_data    = '0;
        bus.s_valid   = 1'b0;
        bus.s_last    = 1'b0;
        bus.cfg_ready = 1'b0;
        bus.if_rd_pop = 1'b0;
        bus.st_last   = 1'b0;
        #2 areset = 1'b1;
        repeat (3) @(posedge aclk);
        #1;
        checkResetOutputs("reset");
        areset = 1'b0;
        repeat (2) @(posedge aclk);
        #1;
        checkOutput("s_ready_idle", DW'(bus.s_ready), 1);

        $display("[TB] 16-beat packet, no padding");
        bus.cfg_ready = 1'b1;
        applyStimulus(1, 16);
        waitDescriptor(50);
        checkOutput("a_pending", DW'(pkt_pending), 1);
        checkOutput("a_rd_req", DW'(bus.if_rd_req), 1);
        popBeats(16);
        checkOutput("a_rd_ready_empty", DW'(bus.if_rd_ready), 0);
        pulseStLast();
        checkOutput("a_pending_done", DW'(pkt_pending), 0);
        pulseStLast();
        checkOutput("pending_no_underflow", DW'(pkt_pending), 0);

        $display("[TB] 5-beat packet padded to one burst");
        applyStimulus(2, 5);
        waitDescriptor(50);
        checkOutput("b_rd_req_8", DW'(bus.if_rd_req), 1);
        checkOutput("b_pending", DW'(pkt_pending), 1);
        popBeats(7);
        checkOutput("b_rd_ready_1", DW'(bus.if_rd_ready), 1);
        checkOutput("b_rd_req_1", DW'(bus.if_rd_req), 0);
        popBeats(1);
        checkOutput("b_rd_ready_0", DW'(bus.if_rd_ready), 0);
        pulseStLast();

        $display("[TB] simultaneous pop and write at count 8");
        applyStimulus(3, 8);
        waitDescriptor(50);
        exp_data.push_back(mkBeat(4, 0));
        pushDesc(8);
        checkOutput("c_s_ready", DW'(bus.s_ready), 1);
        bus.s_data    = mkBeat(4, 0);
        bus.s_valid   = 1'b1;
        bus.if_rd_pop = 1'b1;
        @(posedge aclk);
        #1;
        bus.s_valid   = 1'b0;
        bus.if_rd_pop = 1'b0;
        checkOutput("c_rd_req_8", DW'(bus.if_rd_req), 1);
        popBeats(7);
        checkOutput("c_rd_ready_1", DW'(bus.if_rd_ready), 1);
        checkOutput("c_rd_req_1", DW'(bus.if_rd_req), 0);
        for (int i = 1; i < 8; i++) begin
            exp_data.push_back(mkBeat(4, i));
            sendBeat(mkBeat(4, i), i == 7);
        end
        waitDescriptor(50);
        popBeats(8);
        pulseStLast();
        pulseStLast();
        checkOutput("c_pending_done", DW'(pkt_pending), 0);

        $display("[TB] reload, then descriptor held off by cfg_ready");
        cfg_reload = 1'b1;
        @(posedge aclk);
        #1;
        cfg_reload    = 1'b0;
        exp_sub       = '0;
        bus.cfg_ready = 1'b0;
        applyStimulus(5, 8);
        for (int i = 1; i <= 20; i++) begin
            @(posedge aclk);
            #1;
            if (i == 1 || i == 20) begin
                checkOutput("d_hold_s_ready", DW'(bus.s_ready), 0);
                checkOutput("d_hold_cfg_valid", DW'(bus.cfg_valid), 1);
            end
        end
        checkOutput("d_hold_pending", DW'(pkt_pending), 0);
        bus.cfg_ready = 1'b1;
        waitDescriptor(10);
        checkOutput("d_pending_1", DW'(pkt_pending), 1);
        bus.cfg_ready = 1'b0;
        applyStimulus(6, 8);
        bus.cfg_ready = 1'b1;
        bus.st_last   = 1'b1;
        @(posedge aclk);
        #1;
        bus.st_last = 1'b0;
        checkOutput("d_issue_and_done", DW'(pkt_pending), 1);
        popBeats(16);
        pulseStLast();
        checkOutput("d_pending_done", DW'(pkt_pending), 0);

        $display("[TB] oversize packet truncation");
        checkOutput("e_ovf_before", DW'(ovf), 0);
        applyStimulus(7, 20);
        waitDescriptor(50);
        checkOutput("e_ovf_after", DW'(ovf), 1);
        checkOutput("e_rd_req", DW'(bus.if_rd_req), 1);
        popBeats(16);
        checkOutput("e_rd_ready_empty", DW'(bus.if_rd_ready), 0);
        pulseStLast();

        $display("[TB] reset during padding");
        applyStimulus(8, 3);
        @(posedge aclk);
        #2 areset = 1'b1;
        #1;
        checkResetOutputs("midpad");
        exp_desc.delete();
        exp_data.delete();
        cfg_base_addr = {3'd3, 2'd1, 20'h00400};
        exp_sub       = 20'h00400;
        repeat (2) @(posedge aclk);
        #1 areset = 1'b0;
        repeat (2) @(posedge aclk);
        #1;
        applyStimulus(9, 2);
        waitDescriptor(50);
        checkOutput("f_pending", DW'(pkt_pending), 1);
        popBeats(8);
        checkOutput("f_rd_ready_empty", DW'(bus.if_rd_ready), 0);

        checkOutput("desc_queue_drained", DW'(exp_desc.size()), 0);
        checkOutput("data_queue_drained", DW'(exp_data.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
